// File: rtl/conv3x3_relu_engine.sv
// Two-pass 3x3 valid-padding convolution over a buffered 30x30 image with bias,
// ReLU and 8-bit requantization; results are packed 8 pixels per DRAM word.
module conv3x3_relu_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ifmap,
  input  logic [71:0] filter,
  input  logic [15:0] bias,
  output logic        DRAMreadEn,
  output logic [9:0]  DRAMreadAddr,
  output logic        DRAMwriteEn,
  output logic [9:0]  DRAMwriteAddr,
  output logic [63:0] DRAMwriteData
);
  localparam logic [6:0] LAST_READ = 7'd113;
  localparam logic [9:0] LAST_ADDR = 10'd113;
  localparam logic [4:0] LAST_POS  = 5'd27;

  typedef enum logic [1:0] {LOAD, PASS0, PASS1, DONE} state_t;
  state_t state, state_next;

  logic [7:0]  pix [904];
  logic [6:0]  rd_cnt;
  logic [9:0]  cap_addr;
  logic        cap_valid;
  logic        b_loaded;
  logic [71:0] w_reg;
  logic [15:0] b_reg;
  logic [4:0]  ox, oy;
  logic [2:0]  lane;
  logic [7:0]  wr_cnt;
  logic [55:0] pack;
  logic        issue, buf_wr, latch_a, latch_b, compute, last_pos;
  logic [9:0]  base;
  logic signed [20:0] acc, pe, we, shifted;
  logic [7:0]  q;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (latch_a) state_next = PASS0;
      PASS0:   if (compute && last_pos) state_next = PASS1;
      PASS1:   if (compute && last_pos) state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  // Word 113 is only a terminator: its capture edge is where set A is sampled.
  always_comb begin
    issue    = (state == LOAD) && (rd_cnt <= LAST_READ);
    buf_wr   = (state == LOAD) && cap_valid && (cap_addr != LAST_ADDR);
    latch_a  = (state == LOAD) && cap_valid && (cap_addr == LAST_ADDR);
    latch_b  = (state == PASS1) && !b_loaded;
    compute  = (state == PASS0) || ((state == PASS1) && b_loaded);
    last_pos = (ox == LAST_POS) && (oy == LAST_POS);
  end

  always_comb begin
    base = 10'(oy) * 10'd30 + 10'(ox);
    acc  = {{5{b_reg[15]}}, b_reg};
    pe   = '0;
    we   = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pe  = {13'd0, pix[base + 10'(30 * i + j)]};
        we  = {{13{w_reg[71 - 8 * (3 * i + j)]}}, w_reg[71 - 8 * (3 * i + j) -: 8]};
        acc = acc + pe * we;
      end
    end
    shifted = acc >>> 4;
    if (acc < 0)                 q = 8'd0;
    else if (shifted > 21'sd255) q = 8'hFF;
    else                         q = shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (buf_wr)
      for (int j = 0; j < 8; j++)
        pix[{cap_addr[6:0], 3'b000} + 10'(j)] <= ifmap[8 * j +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt        <= '0;
      cap_valid     <= 1'b0;
      cap_addr      <= '0;
      b_loaded      <= 1'b0;
      w_reg         <= '0;
      b_reg         <= '0;
      ox            <= '0;
      oy            <= '0;
      lane          <= '0;
      wr_cnt        <= '0;
      pack          <= '0;
      DRAMreadEn    <= 1'b0;
      DRAMreadAddr  <= '0;
      DRAMwriteEn   <= 1'b0;
      DRAMwriteAddr <= '0;
      DRAMwriteData <= '0;
    end else begin
      cap_valid   <= DRAMreadEn;
      cap_addr    <= DRAMreadAddr;
      DRAMreadEn  <= issue;
      DRAMwriteEn <= 1'b0;
      if (issue) begin
        DRAMreadAddr <= {3'b000, rd_cnt};
        rd_cnt       <= rd_cnt + 7'd1;
      end
      if (latch_a || latch_b) begin
        w_reg <= filter;
        b_reg <= bias;
      end
      if (latch_b) b_loaded <= 1'b1;
      // Write addresses run 0..195 straight through both passes.
      if (compute) begin
        if (lane == 3'd7) begin
          DRAMwriteEn   <= 1'b1;
          DRAMwriteAddr <= {2'b00, wr_cnt};
          DRAMwriteData <= {q, pack};
          wr_cnt        <= wr_cnt + 8'd1;
        end else begin
          pack[{lane, 3'b000} +: 8] <= q;
        end
        lane <= lane + 3'd1;
        if (ox == LAST_POS) begin
          ox <= '0;
          oy <= (oy == LAST_POS) ? 5'd0 : oy + 5'd1;
        end else begin
          ox <= ox + 5'd1;
        end
      end
      if (state == DONE) begin
        DRAMreadEn    <= 1'b0;
        DRAMreadAddr  <= '0;
        DRAMwriteEn   <= 1'b0;
        DRAMwriteAddr <= '0;
        DRAMwriteData <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_relu_engine.sv
// Bench for conv3x3_relu_engine: a DRAM responder feeds the image, and written words
// are compared with a direct arithmetic convolution model.
module tb_conv3x3_relu_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ifmap = '0;
  logic [71:0] filter = '0;
  logic [15:0] bias = '0;
  logic        DRAMreadEn, DRAMwriteEn;
  logic [9:0]  DRAMreadAddr, DRAMwriteAddr;
  logic [63:0] DRAMwriteData;

  conv3x3_relu_engine dut (
    .clk(clk), .rst(rst), .ifmap(ifmap), .filter(filter), .bias(bias),
    .DRAMreadEn(DRAMreadEn), .DRAMreadAddr(DRAMreadAddr),
    .DRAMwriteEn(DRAMwriteEn), .DRAMwriteAddr(DRAMwriteAddr),
    .DRAMwriteData(DRAMwriteData)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int img [900];
  int wa [9];
  int wb [9];
  int ba, bb;
  logic [63:0] wr_data [196];
  int wr_addr [196];
  int n_reads, n_writes, first_read_cyc, last_write_cyc, extra_activity;
  bit reads_ok, final_zero;

  function automatic logic [71:0] pack_filter(input int w [9]);
    logic [71:0] f = '0;
    for (int k = 0; k < 9; k++) f[71 - 8 * k -: 8] = 8'(w[k]);
    return f;
  endfunction

  function automatic logic [63:0] dram_word(input int a);
    logic [63:0] d = '0;
    for (int l = 0; l < 8; l++) begin
      int p = a * 8 + l;
      d[8 * l +: 8] = (p < 900) ? 8'(img[p]) : 8'($urandom_range(0, 255));
    end
    return d;
  endfunction

  // Output pixel k of pass f lives at word 98f + k/8, lane k%8.
  function automatic logic [63:0] expect_word(input int a);
    logic [63:0] d = '0;
    int f = a / 98;
    for (int l = 0; l < 8; l++) begin
      int k = (a % 98) * 8 + l;
      int oy = k / 28;
      int ox = k % 28;
      int acc = (f == 0) ? ba : bb;
      int o;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += img[(oy + i) * 30 + ox + j] * ((f == 0) ? wa[3 * i + j] : wb[3 * i + j]);
      o = (acc < 0) ? 0 : ((acc / 16 > 255) ? 255 : acc / 16);
      d[8 * l +: 8] = 8'(o);
    end
    return d;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Plays DRAM for up to max_cycles; set B is presented only after word 113 is captured.
  task automatic run_job(input int max_cycles, input bit to_done);
    bit pending = 1'b0;
    int pend_addr = 0;
    int change_at = -1;
    filter = pack_filter(wa);
    bias = 16'(ba);
    n_reads = 0; n_writes = 0; first_read_cyc = -1; last_write_cyc = -1;
    extra_activity = 0; reads_ok = 1'b1; final_zero = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(posedge clk);
      #1;
      ifmap = pending ? dram_word(pend_addr) : {$urandom, $urandom};
      if (cyc == change_at) begin
        filter = pack_filter(wb);
        bias = 16'(bb);
      end
      pending = DRAMreadEn;
      pend_addr = int'(DRAMreadAddr);
      if (DRAMreadEn) begin
        if (first_read_cyc < 0) first_read_cyc = cyc;
        if (int'(DRAMreadAddr) != n_reads) reads_ok = 1'b0;
        if (DRAMreadAddr == 10'd113) change_at = cyc + 2;
        if (n_writes >= 196) extra_activity++;
        n_reads++;
      end
      if (DRAMwriteEn) begin
        if (n_writes < 196) begin
          wr_addr[n_writes] = int'(DRAMwriteAddr);
          wr_data[n_writes] = DRAMwriteData;
          last_write_cyc = cyc;
        end else begin
          extra_activity++;
        end
        n_writes++;
      end
      if (to_done && n_writes >= 196 && cyc >= last_write_cyc + 4) begin
        final_zero = !DRAMreadEn && DRAMreadAddr == 10'd0 && !DRAMwriteEn &&
                     DRAMwriteAddr == 10'd0 && DRAMwriteData == 64'd0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int shown = 0;
    for (int p = 0; p < 900; p++) img[p] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) begin
      wa[k] = int'($urandom_range(0, 20)) - 10;
      wb[k] = int'($urandom_range(0, 20)) - 10;
    end
    ba = int'($urandom_range(0, 3000)) - 1500;
    bb = int'($urandom_range(0, 3000)) - 1500;
    do_reset();
    run_job(400, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (DRAMreadEn !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_readEn: got %b, expected 0", DRAMreadEn); end
    tests_run++;
    if (DRAMreadAddr !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_readAddr: got %0d, expected 0", DRAMreadAddr); end
    tests_run++;
    if (DRAMwriteEn !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_writeEn: got %b, expected 0", DRAMwriteEn); end
    tests_run++;
    if (DRAMwriteAddr !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_writeAddr: got %0d, expected 0", DRAMwriteAddr); end
    tests_run++;
    if (DRAMwriteData !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_writeData: got %h, expected 0", DRAMwriteData); end
    @(posedge clk);
    #1 rst = 1'b0;
    run_job(2000, 1'b1);
    tests_run++;
    if (first_read_cyc !== 0) begin tests_failed++; $display("[TB] FAIL restart_first_read: got cycle %0d, expected 0", first_read_cyc); end
    tests_run++;
    if (n_reads !== 114 || !reads_ok) begin tests_failed++; $display("[TB] FAIL restart_reads: got %0d reads contiguous=%0b, expected 114 contiguous", n_reads, reads_ok); end
    tests_run++;
    if (n_writes !== 196) begin tests_failed++; $display("[TB] FAIL restart_write_count: got %0d, expected 196", n_writes); end
    for (int i = 0; i < 196 && i < n_writes; i++) begin
      tests_run++;
      if (wr_addr[i] !== i || wr_data[i] !== expect_word(i)) begin
        tests_failed++;
        if (shown++ < 5) $display("[TB] FAIL restart_word%0d: got addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, expect_word(i));
      end
    end
  endtask

  task automatic test_relu_ones;
    int shown = 0;
    for (int p = 0; p < 900; p++) img[p] = 1;
    wa = '{-7, -19, 26, 13, -15, -12, 16, 10, -15};
    ba = 459;
    wb = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    bb = -100;
    do_reset();
    run_job(2000, 1'b1);
    tests_run++;
    if (n_writes !== 196) begin tests_failed++; $display("[TB] FAIL ones_write_count: got %0d, expected 196", n_writes); end
    for (int i = 0; i < 196 && i < n_writes; i++) begin
      tests_run++;
      if (wr_addr[i] !== i || wr_data[i] !== expect_word(i)) begin
        tests_failed++;
        if (shown++ < 5) $display("[TB] FAIL ones_word%0d: got addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, expect_word(i));
      end
    end
  endtask

  task automatic test_saturate;
    int shown = 0;
    for (int p = 0; p < 900; p++) img[p] = 255;
    for (int k = 0; k < 9; k++) begin
      wa[k] = 127;
      wb[k] = int'($urandom_range(0, 255)) - 128;
    end
    ba = 0;
    bb = int'($urandom_range(0, 65535)) - 32768;
    do_reset();
    run_job(2000, 1'b1);
    tests_run++;
    if (n_writes !== 196) begin tests_failed++; $display("[TB] FAIL sat_write_count: got %0d, expected 196", n_writes); end
    for (int i = 0; i < 196 && i < n_writes; i++) begin
      tests_run++;
      if (wr_addr[i] !== i || wr_data[i] !== expect_word(i)) begin
        tests_failed++;
        if (shown++ < 5) $display("[TB] FAIL sat_word%0d: got addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, expect_word(i));
      end
    end
  endtask

  task automatic test_ramp;
    int shown = 0;
    for (int p = 0; p < 900; p++) img[p] = p % 256;
    wa = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
    ba = 0;
    wb = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    bb = -500;
    do_reset();
    run_job(2000, 1'b1);
    tests_run++;
    if (n_writes !== 196) begin tests_failed++; $display("[TB] FAIL ramp_write_count: got %0d, expected 196", n_writes); end
    for (int i = 0; i < 196 && i < n_writes; i++) begin
      tests_run++;
      if (wr_addr[i] !== i || wr_data[i] !== expect_word(i)) begin
        tests_failed++;
        if (shown++ < 5) $display("[TB] FAIL ramp_word%0d: got addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, expect_word(i));
      end
    end
  endtask

  task automatic test_filter_change;
    int shown = 0;
    for (int p = 0; p < 900; p++) img[p] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) begin
      wa[k] = int'($urandom_range(0, 20)) - 10;
      wb[k] = int'($urandom_range(0, 20)) - 10;
    end
    wb[0] = wa[0] + 11;
    ba = int'($urandom_range(0, 3000)) - 1500;
    bb = int'($urandom_range(0, 3000)) - 1500;
    do_reset();
    run_job(2000, 1'b1);
    tests_run++;
    if (n_writes !== 196) begin tests_failed++; $display("[TB] FAIL change_write_count: got %0d, expected 196", n_writes); end
    for (int i = 0; i < 196 && i < n_writes; i++) begin
      tests_run++;
      if (wr_addr[i] !== i || wr_data[i] !== expect_word(i)) begin
        tests_failed++;
        if (shown++ < 5) $display("[TB] FAIL change_word%0d: got addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, expect_word(i));
      end
    end
    tests_run++;
    if (last_write_cyc < 0 || last_write_cyc >= 114 + 2 * 784 + 16) begin
      tests_failed++;
      $display("[TB] FAIL change_runtime: got last write at cycle %0d, expected below %0d", last_write_cyc, 114 + 2 * 784 + 16);
    end
    tests_run++;
    if (extra_activity !== 0) begin tests_failed++; $display("[TB] FAIL done_activity: got %0d extra accesses, expected 0", extra_activity); end
    tests_run++;
    if (final_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_outputs: got nonzero outputs, expected all 0"); end
  endtask

  initial begin
    test_reset();
    test_relu_ones();
    test_saturate();
    test_ramp();
    test_filter_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
